// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
// Holds the request op-code encoding, the controller state encoding and the
// default stack-top address used as the SP reset value.
package mem_ctrl_pkg;

   localparam logic [10:0] STACK_TOP_DEFAULT = 11'h7FF;

   typedef enum logic [2:0] {
      OP_LOAD   = 3'd0,
      OP_STORE  = 3'd1,
      OP_PUSH   = 3'd2,
      OP_POP    = 3'd3,
      OP_PUSH32 = 3'd4,
      OP_POP32  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC0,
      ST_ACC1
   } state_e;

endpackage

// File: rtl/sp_unit.sv
// Stack pointer register with limit checking.
// Optional feature macro: STACK_CHECK_EN (enables push/pop limit faults).
//
// Ports:
//   clk, rst_n  clock, async active-low reset (SP returns to STACK_TOP)
//   op          op code of the request being executed
//   inc, dec    step SP by +1 / -1 at the next edge (one step per word)
//   sp          current stack pointer
//   sp_up       sp + 1, the address a pop reads
//   fault       op would cross a stack limit (always 0 without STACK_CHECK_EN)
//
// Two-word ops step once per word, so PUSH32/POP32 move SP by 2 in total
// and the second word's address is simply the current SP (or SP+1) again.
module sp_unit
   import mem_ctrl_pkg::*;
#(
   parameter int                ADDR_W    = 11,
   parameter logic [ADDR_W-1:0] STACK_TOP = ADDR_W'(STACK_TOP_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        op,
   input  logic              inc,
   input  logic              dec,
   output logic [ADDR_W-1:0] sp,
   output logic [ADDR_W-1:0] sp_up,
   output logic              fault
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   sp <= STACK_TOP;
      else if (dec) sp <= sp - ADDR_W'(1);
      else if (inc) sp <= sp + ADDR_W'(1);
   end

   assign sp_up = sp + ADDR_W'(1);

`ifdef STACK_CHECK_EN
   always_comb begin
      fault = 1'b0;
      case (op)
         OP_PUSH:   fault = (sp == '0);
         OP_PUSH32: fault = (sp < ADDR_W'(2));
         OP_POP:    fault = (sp == STACK_TOP);
         OP_POP32:  fault = (sp > STACK_TOP - ADDR_W'(2));
         default:   fault = 1'b0;
      endcase
   end
`else
   logic unused_op;
   assign unused_op = ^op;
   assign fault     = 1'b0;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: LOAD/STORE plus 16- and 32-bit stack ops
// against a single-port 16-bit memory with combinational read data.
// Optional feature macro: STACK_CHECK_EN (stack limit faults, see sp_unit).
//
// Ports:
//   Clk, Rst_n                 clock, async active-low reset
//   ReqValid/ReqReady          request handshake; ready only in IDLE
//   ReqOp, ReqAddr, ReqWData   op code, LOAD/STORE address, store/push data
//   RspValid, RspData          one-cycle read result strobe and data
//   Err                        one-cycle stack-fault / illegal-op strobe
//   SP                         current stack pointer
//   MemeRead, MemeWrite        one-cycle word read / write strobes
//   MemAddr, MemWData, MemRData  memory address, write data, read data
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request (after the first edge out of reset)
// ACC0    | first (or only) word access, or Err for faults/illegal ops
// ACC1    | second word of PUSH32 / POP32
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int                ADDR_W    = 11,
   parameter logic [ADDR_W-1:0] STACK_TOP = ADDR_W'(STACK_TOP_DEFAULT)
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic [2:0]        ReqOp,
   input  logic [ADDR_W-1:0] ReqAddr,
   input  logic [31:0]       ReqWData,
   output logic              RspValid,
   output logic [31:0]       RspData,
   output logic              Err,
   output logic [ADDR_W-1:0] SP,
   output logic              MemeRead,
   output logic              MemeWrite,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [15:0]       MemWData,
   input  logic [15:0]       MemRData
);

   state_e            state, state_nxt;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [15:0]       lo_q;
   logic              started;
   logic              accept;
   logic              sp_inc, sp_dec, fault;
   logic [ADDR_W-1:0] sp_up;
   logic              lo_cap, rsp_fin16, rsp_fin32;

   sp_unit #(.ADDR_W(ADDR_W), .STACK_TOP(STACK_TOP)) u_sp (
      .clk   (Clk),
      .rst_n (Rst_n),
      .op    (op_q),
      .inc   (sp_inc),
      .dec   (sp_dec),
      .sp    (SP),
      .sp_up (sp_up),
      .fault (fault)
   );

   // started holds ready low until the first edge after reset release
   assign ReqReady = started && (state == ST_IDLE);
   assign accept   = ReqValid && ReqReady;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state    <= ST_IDLE;
         started  <= 1'b0;
         op_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         lo_q     <= '0;
         RspValid <= 1'b0;
         RspData  <= '0;
      end else begin
         state    <= state_nxt;
         started  <= 1'b1;
         RspValid <= rsp_fin16 | rsp_fin32;
         if (accept) begin
            op_q    <= ReqOp;
            addr_q  <= ReqAddr;
            wdata_q <= ReqWData;
         end
         // MemRData is only trusted at the edge closing a read cycle
         if (lo_cap)         lo_q    <= MemRData;
         if (rsp_fin16)      RspData <= {16'h0000, MemRData};
         else if (rsp_fin32) RspData <= {MemRData, lo_q};
      end
   end

   always_comb begin
      state_nxt = state;
      MemeRead  = 1'b0;
      MemeWrite = 1'b0;
      MemAddr   = '0;
      MemWData  = '0;
      Err       = 1'b0;
      sp_inc    = 1'b0;
      sp_dec    = 1'b0;
      lo_cap    = 1'b0;
      rsp_fin16 = 1'b0;
      rsp_fin32 = 1'b0;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_ACC0;
         ST_ACC0: begin
            state_nxt = ST_IDLE;
            case (op_q)
               OP_LOAD: begin
                  MemeRead  = 1'b1;
                  MemAddr   = addr_q;
                  rsp_fin16 = 1'b1;
               end
               OP_STORE: begin
                  MemeWrite = 1'b1;
                  MemAddr   = addr_q;
                  MemWData  = wdata_q[15:0];
               end
               OP_PUSH, OP_PUSH32: begin
                  if (fault) Err = 1'b1;
                  else begin
                     MemeWrite = 1'b1;
                     MemAddr   = SP;
                     sp_dec    = 1'b1;
                     if (op_q == OP_PUSH32) begin
                        MemWData  = wdata_q[31:16];
                        state_nxt = ST_ACC1;
                     end else begin
                        MemWData  = wdata_q[15:0];
                     end
                  end
               end
               OP_POP, OP_POP32: begin
                  if (fault) Err = 1'b1;
                  else begin
                     MemeRead = 1'b1;
                     MemAddr  = sp_up;
                     sp_inc   = 1'b1;
                     if (op_q == OP_POP32) begin
                        lo_cap    = 1'b1;
                        state_nxt = ST_ACC1;
                     end else begin
                        rsp_fin16 = 1'b1;
                     end
                  end
               end
               default: Err = 1'b1;
            endcase
         end
         ST_ACC1: begin
            // only PUSH32 and POP32 reach here; SP already moved one word
            state_nxt = ST_IDLE;
            if (op_q == OP_PUSH32) begin
               MemeWrite = 1'b1;
               MemAddr   = SP;
               MemWData  = wdata_q[15:0];
               sp_dec    = 1'b1;
            end else begin
               MemeRead  = 1'b1;
               MemAddr   = sp_up;
               sp_inc    = 1'b1;
               rsp_fin32 = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural memory and a
// reference model of the stack/memory semantics.
// Honours STACK_CHECK_EN the same way the design does.
module tb_mem_access_ctrl;

   localparam int          AW  = 11;
   localparam logic [10:0] TOP = 11'h7FF;

   logic          Clk = 1'b0;
   logic          Rst_n = 1'b0;
   logic          ReqValid, ReqReady;
   logic [2:0]    ReqOp;
   logic [AW-1:0] ReqAddr;
   logic [31:0]   ReqWData;
   logic          RspValid;
   logic [31:0]   RspData;
   logic          Err;
   logic [AW-1:0] SP;
   logic          MemeRead, MemeWrite;
   logic [AW-1:0] MemAddr;
   logic [15:0]   MemWData, MemRData;

   int checks = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   mem_access_ctrl dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
      .ReqAddr(ReqAddr), .ReqWData(ReqWData),
      .RspValid(RspValid), .RspData(RspData), .Err(Err), .SP(SP),
      .MemeRead(MemeRead), .MemeWrite(MemeWrite), .MemAddr(MemAddr),
      .MemWData(MemWData), .MemRData(MemRData)
   );

   // memory seen by the DUT; read data is junk unless a read is in progress
   logic [15:0] mem     [0:2047];
   logic [15:0] mem_ref [0:2047];
   logic [10:0] sp_ref;

   assign MemRData = MemeRead ? mem[MemAddr] : 16'h5A5A;
   always @(posedge Clk) if (MemeWrite) mem[MemAddr] <= MemWData;

   int n_rd = 0, n_wr = 0, n_err = 0, n_both = 0;
   always @(posedge Clk) begin
      if (MemeRead)              n_rd++;
      if (MemeWrite)             n_wr++;
      if (Err)                   n_err++;
      if (MemeRead && MemeWrite) n_both++;
   end

   // Reference: what one request does to the stack and memory, and what
   // it should produce (latency accept->ready, response, err/read/write counts).
   task automatic model_op(input int op, input logic [10:0] addr, input logic [31:0] wd,
                           output int lat, output logic rv, output logic [31:0] rd,
                           output int ne, output int nr, output int nw);
      bit chk;
`ifdef STACK_CHECK_EN
      chk = 1'b1;
`else
      chk = 1'b0;
`endif
      lat = 2; rv = 1'b0; rd = '0; ne = 0; nr = 0; nw = 0;
      case (op)
         0: begin rv = 1'b1; rd = {16'h0, mem_ref[addr]}; nr = 1; end
         1: begin mem_ref[addr] = wd[15:0]; nw = 1; end
         2: if (chk && sp_ref == 11'd0) ne = 1;
            else begin mem_ref[sp_ref] = wd[15:0]; sp_ref = sp_ref - 11'd1; nw = 1; end
         3: if (chk && sp_ref == TOP) ne = 1;
            else begin sp_ref = sp_ref + 11'd1; rd = {16'h0, mem_ref[sp_ref]}; rv = 1'b1; nr = 1; end
         4: if (chk && sp_ref < 11'd2) ne = 1;
            else begin
               lat = 3; nw = 2;
               mem_ref[sp_ref] = wd[31:16];
               mem_ref[sp_ref - 11'd1] = wd[15:0];
               sp_ref = sp_ref - 11'd2;
            end
         5: if (chk && sp_ref > TOP - 11'd2) ne = 1;
            else begin
               lat = 3; nr = 2; rv = 1'b1;
               rd = {mem_ref[sp_ref + 11'd2], mem_ref[sp_ref + 11'd1]};
               sp_ref = sp_ref + 11'd2;
            end
         default: ne = 1;
      endcase
   endtask

   // Drives one request and reports what was observed; no judgement here.
   task automatic run_op(input int op, input logic [10:0] addr, input logic [31:0] wd,
                         output int lat, output logic rv, output logic [31:0] rd,
                         output int ne, output int nr, output int nw);
      int e0, r0, w0;
      @(negedge Clk);
      ReqValid = 1'b1; ReqOp = op[2:0]; ReqAddr = addr; ReqWData = wd;
      lat = 0;
      while (!ReqReady && lat < 20) begin @(negedge Clk); lat++; end
      e0 = n_err; r0 = n_rd; w0 = n_wr;
      @(negedge Clk); ReqValid = 1'b0; lat = 1;
      while (!ReqReady && lat < 20) begin @(negedge Clk); lat++; end
      rv = RspValid; rd = RspData;
      ne = n_err - e0; nr = n_rd - r0; nw = n_wr - w0;
   endtask

   task automatic apply_reset;
      @(negedge Clk); Rst_n = 1'b0; ReqValid = 1'b0;
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1; sp_ref = TOP;
      @(negedge Clk);
   endtask

   task automatic test_reset;
      @(negedge Clk);
      checks++;
      if ({ReqReady, MemeRead, MemeWrite, RspValid, Err} !== 5'b0) begin
         failures++; $display("FAIL reset_strobes got=%b exp=00000", {ReqReady, MemeRead, MemeWrite, RspValid, Err});
      end
      checks++;
      if (SP !== TOP || MemAddr !== 11'h0 || MemWData !== 16'h0 || RspData !== 32'h0) begin
         failures++; $display("FAIL reset_values sp=%h addr=%h wdata=%h rsp=%h exp sp=7ff others 0", SP, MemAddr, MemWData, RspData);
      end
      Rst_n = 1'b1; sp_ref = TOP;
      @(negedge Clk);
      checks++;
      if (ReqReady !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ReqReady); end
   endtask

   task automatic test_store_load;
      int lat, ne, nr, nw, elat, ene, enr, enw; logic rv, erv; logic [31:0] rd, erd;
      model_op(1, 11'h010, 32'h0000BEEF, elat, erv, erd, ene, enr, enw);
      run_op(1, 11'h010, 32'h0000BEEF, lat, rv, rd, ne, nr, nw);
      checks++;
      if (lat !== 2 || rv !== 1'b0 || nw !== 1 || nr !== 0) begin
         failures++; $display("FAIL store lat=%0d rv=%b wr=%0d rd=%0d exp 2/0/1/0", lat, rv, nw, nr);
      end
      checks++;
      if (mem[11'h010] !== 16'hBEEF) begin failures++; $display("FAIL store_mem got=%h exp=beef", mem[11'h010]); end
      model_op(0, 11'h010, 32'h0, elat, erv, erd, ene, enr, enw);
      run_op(0, 11'h010, 32'h0, lat, rv, rd, ne, nr, nw);
      checks++;
      if (rv !== 1'b1 || rd !== 32'h0000BEEF) begin failures++; $display("FAIL load_rsp rv=%b data=%h exp 1/0000beef", rv, rd); end
      checks++;
      if (nr !== 1 || nw !== 0 || lat !== 2) begin failures++; $display("FAIL load_reads rd=%0d wr=%0d lat=%0d exp 1/0/2", nr, nw, lat); end
      @(negedge Clk);
      checks++;
      if (RspValid !== 1'b0) begin failures++; $display("FAIL load_rsp_width got=%b exp=0", RspValid); end
   endtask

   task automatic test_push32_pop32;
      int lat, ne, nr, nw, elat, ene, enr, enw; logic rv, erv; logic [31:0] rd, erd;
      apply_reset();
      model_op(4, 11'h0, 32'h12345678, elat, erv, erd, ene, enr, enw);
      run_op(4, 11'h0, 32'h12345678, lat, rv, rd, ne, nr, nw);
      checks++;
      if (mem[11'h7FF] !== 16'h1234 || mem[11'h7FE] !== 16'h5678) begin
         failures++; $display("FAIL push32_mem got %h/%h exp 1234/5678", mem[11'h7FF], mem[11'h7FE]);
      end
      checks++;
      if (SP !== 11'h7FD || lat !== 3 || nw !== 2) begin failures++; $display("FAIL push32_sp sp=%h lat=%0d wr=%0d exp 7fd/3/2", SP, lat, nw); end
      model_op(5, 11'h0, 32'h0, elat, erv, erd, ene, enr, enw);
      run_op(5, 11'h0, 32'h0, lat, rv, rd, ne, nr, nw);
      checks++;
      if (rv !== 1'b1 || rd !== 32'h12345678) begin failures++; $display("FAIL pop32_rsp rv=%b data=%h exp 1/12345678", rv, rd); end
      checks++;
      if (SP !== 11'h7FF || lat !== 3 || nr !== 2) begin failures++; $display("FAIL pop32_sp sp=%h lat=%0d rd=%0d exp 7ff/3/2", SP, lat, nr); end
   endtask

   task automatic test_back_to_back;
      int acc[3]; int k, cyc, lat, ne, nr, nw, elat, ene, enr, enw;
      logic rv, erv; logic [31:0] rd, erd;
      apply_reset();
      for (int i = 1; i <= 3; i++) model_op(2, 11'h0, 32'(i), elat, erv, erd, ene, enr, enw);
      k = 0; cyc = 0;
      @(negedge Clk); ReqValid = 1'b1; ReqOp = 3'd2; ReqWData = 32'd1;
      while (k < 3 && cyc < 30) begin
         if (ReqReady) begin acc[k] = cyc; k++; end
         @(negedge Clk); cyc++;
         if (k < 3) ReqWData = 32'(k + 1); else ReqValid = 1'b0;
      end
      ReqValid = 1'b0;
      @(negedge Clk);
      checks++;
      if (k !== 3 || acc[1] - acc[0] !== 2 || acc[2] - acc[1] !== 2) begin
         failures++; $display("FAIL b2b_spacing accepts=%0d gaps=%0d/%0d exp 3/2/2", k, acc[1] - acc[0], acc[2] - acc[1]);
      end
      checks++;
      if (SP !== 11'h7FC) begin failures++; $display("FAIL b2b_sp got=%h exp=7fc", SP); end
      for (int i = 0; i < 3; i++) begin
         model_op(3, 11'h0, 32'h0, elat, erv, erd, ene, enr, enw);
         run_op(3, 11'h0, 32'h0, lat, rv, rd, ne, nr, nw);
         checks++;
         if (rv !== 1'b1 || rd !== 32'(3 - i)) begin failures++; $display("FAIL b2b_pop%0d rv=%b data=%h exp 1/%h", i, rv, rd, 32'(3 - i)); end
      end
      checks++;
      if (SP !== 11'h7FF) begin failures++; $display("FAIL b2b_pop_sp got=%h exp=7ff", SP); end
   endtask

   task automatic test_pop_empty;
      int lat, ne, nr, nw, elat, ene, enr, enw; logic rv, erv; logic [31:0] rd, erd;
      apply_reset();
      model_op(3, 11'h0, 32'h0, elat, erv, erd, ene, enr, enw);
      run_op(3, 11'h0, 32'h0, lat, rv, rd, ne, nr, nw);
      checks++;
      if (ne !== ene || nr !== enr || rv !== erv || (erv && rd !== erd)) begin
         failures++; $display("FAIL pop_empty err=%0d rd=%0d rv=%b data=%h exp %0d/%0d/%b/%h", ne, nr, rv, rd, ene, enr, erv, erd);
      end
      checks++;
      if (SP !== sp_ref) begin failures++; $display("FAIL pop_empty_sp got=%h exp=%h", SP, sp_ref); end
   endtask

   task automatic test_illegal;
      int lat, ne, nr, nw, elat, ene, enr, enw; logic rv, erv; logic [31:0] rd, erd;
      logic [10:0] sp0;
      for (int op = 6; op <= 7; op++) begin
         sp0 = SP;
         model_op(op, 11'h055, 32'hFFFF_FFFF, elat, erv, erd, ene, enr, enw);
         run_op(op, 11'h055, 32'hFFFF_FFFF, lat, rv, rd, ne, nr, nw);
         checks++;
         if (ne !== 1 || nr !== 0 || nw !== 0 || lat !== 2 || rv !== 1'b0) begin
            failures++; $display("FAIL illegal%0d err=%0d rd=%0d wr=%0d lat=%0d rv=%b exp 1/0/0/2/0", op, ne, nr, nw, lat, rv);
         end
         checks++;
         if (SP !== sp0) begin failures++; $display("FAIL illegal%0d_sp got=%h exp=%h", op, SP, sp0); end
      end
   endtask

   task automatic test_reset_mid_op;
      apply_reset();
      @(negedge Clk); ReqValid = 1'b1; ReqOp = 3'd4; ReqWData = 32'hCAFEF00D;
      @(negedge Clk); ReqValid = 1'b0;
      @(negedge Clk);
      checks++;
      if (MemeWrite !== 1'b1 || MemAddr !== 11'h7FE) begin
         failures++; $display("FAIL mid_acc1 write=%b addr=%h exp 1/7fe", MemeWrite, MemAddr);
      end
      Rst_n = 1'b0;
      #1;
      checks++;
      if ({MemeWrite, MemeRead, RspValid, Err, ReqReady} !== 5'b0 || SP !== TOP || RspData !== 32'h0) begin
         failures++; $display("FAIL mid_reset strobes=%b sp=%h rsp=%h exp 00000/7ff/0", {MemeWrite, MemeRead, RspValid, Err, ReqReady}, SP, RspData);
      end
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      checks++;
      if (ReqReady !== 1'b1 || RspValid !== 1'b0 || SP !== TOP) begin
         failures++; $display("FAIL mid_release ready=%b rv=%b sp=%h exp 1/0/7ff", ReqReady, RspValid, SP);
      end
      checks++;
      if (mem[11'h7FF] !== 16'hCAFE || mem[11'h7FE] !== mem_ref[11'h7FE]) begin
         failures++; $display("FAIL mid_mem got %h/%h exp cafe/%h", mem[11'h7FF], mem[11'h7FE], mem_ref[11'h7FE]);
      end
      mem_ref[11'h7FF] = 16'hCAFE;
      sp_ref = TOP;
   endtask

   task automatic test_random;
      int op, lat, ne, nr, nw, elat, ene, enr, enw, bad;
      logic rv, erv; logic [31:0] rd, erd, wd; logic [10:0] addr;
      for (int i = 0; i < 80; i++) begin
         op = $urandom_range(0, 7);
         addr = 11'($urandom_range(0, 2047));
         wd = $urandom;
         model_op(op, addr, wd, elat, erv, erd, ene, enr, enw);
         run_op(op, addr, wd, lat, rv, rd, ne, nr, nw);
         checks++;
         if (lat !== elat || ne !== ene || nr !== enr || nw !== enw) begin
            failures++; $display("FAIL rand_ctl[%0d] op=%0d lat/err/rd/wr=%0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", i, op, lat, ne, nr, nw, elat, ene, enr, enw);
         end
         checks++;
         if (rv !== erv || (erv && rd !== erd)) begin
            failures++; $display("FAIL rand_rsp[%0d] op=%0d rv=%b data=%h exp %b/%h", i, op, rv, rd, erv, erd);
         end
         checks++;
         if (SP !== sp_ref) begin failures++; $display("FAIL rand_sp[%0d] op=%0d got=%h exp=%h", i, op, SP, sp_ref); end
      end
      bad = 0;
      for (int a = 0; a < 2048; a++) if (mem[a] !== mem_ref[a]) bad++;
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL rand_mem words_differing=%0d exp=0", bad); end
      checks++;
      if (n_both !== 0) begin failures++; $display("FAIL read_write_overlap cycles=%0d exp=0", n_both); end
   endtask

   initial begin
      logic [15:0] v;
      ReqValid = 1'b0; ReqOp = 3'd0; ReqAddr = '0; ReqWData = '0;
      sp_ref = TOP;
      for (int a = 0; a < 2048; a++) begin
         v = 16'($urandom);
         mem[a] = v;
         mem_ref[a] = v;
      end
      test_reset();
      test_store_load();
      test_push32_pop32();
      test_back_to_back();
      test_pop_empty();
      test_illegal();
      test_reset_mid_op();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
      $fatal(1);
   end

endmodule
